// File: rtl/fdc_gate_counter.sv
// FDC front end: synchronises the VCO and ref pins, then counts VCO rising edges
// over a window of gate_len reference periods and presents one result per start.
module fdc_gate_counter #(
  parameter int CNT_W  = 16,
  parameter int GATE_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ena,
  input  logic              vco_in,
  input  logic              ref_in,
  input  logic              start,
  input  logic [GATE_W-1:0] gate_len,
  output logic              busy,
  output logic [CNT_W-1:0]  count,
  output logic              valid,
  output logic              overflow
);

  typedef enum logic [1:0] {IDLE, ARM, MEAS, DONE} state_t;

  state_t              state, state_nxt;
  logic [2:0]          vco_sync, ref_sync;
  logic                vco_p, ref_p;
  logic [GATE_W-1:0]   gate_r, gate_nxt;
  logic [GATE_W-1:0]   ref_cnt, ref_cnt_nxt;
  logic [CNT_W-1:0]    cnt, cnt_nxt;
  logic                ovf_r, ovf_nxt;
  logic                load;

  // [0]/[1] form the two-flop synchroniser, [2] is the edge-detect history
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vco_sync <= '0;
      ref_sync <= '0;
    end else begin
      vco_sync <= {vco_sync[1:0], vco_in};
      ref_sync <= {ref_sync[1:0], ref_in};
    end
  end

  assign vco_p = vco_sync[1] & ~vco_sync[2];
  assign ref_p = ref_sync[1] & ~ref_sync[2];

  always_comb begin
    state_nxt   = state;
    gate_nxt    = gate_r;
    ref_cnt_nxt = ref_cnt;
    cnt_nxt     = cnt;
    ovf_nxt     = ovf_r;
    load        = 1'b0;
    case (state)
      IDLE: if (start) begin
        gate_nxt  = (gate_len == '0) ? GATE_W'(1) : gate_len;
        cnt_nxt   = '0;
        ovf_nxt   = 1'b0;
        state_nxt = ARM;
      end
      // window opens on this ref edge; a coincident VCO edge belongs before it
      ARM: if (ref_p) begin
        ref_cnt_nxt = '0;
        state_nxt   = MEAS;
      end
      MEAS: begin
        if (vco_p) begin
          if (&cnt) ovf_nxt = 1'b1;
          else      cnt_nxt = cnt + CNT_W'(1);
        end
        if (ref_p) begin
          if (ref_cnt == gate_r - GATE_W'(1)) begin
            state_nxt = DONE;
            load      = 1'b1;
          end else begin
            ref_cnt_nxt = ref_cnt + GATE_W'(1);
          end
        end
      end
      DONE: state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
    if (!ena) begin
      state_nxt = IDLE;
      load      = 1'b0;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      gate_r   <= '0;
      ref_cnt  <= '0;
      cnt      <= '0;
      ovf_r    <= 1'b0;
      count    <= '0;
      overflow <= 1'b0;
    end else begin
      state   <= state_nxt;
      gate_r  <= gate_nxt;
      ref_cnt <= ref_cnt_nxt;
      cnt     <= cnt_nxt;
      ovf_r   <= ovf_nxt;
      // result registers load on entry to DONE so count is fresh while valid is high
      if (load) begin
        count    <= cnt_nxt;
        overflow <= ovf_nxt;
      end
    end
  end

  assign valid = (state == DONE);
  assign busy  = (state != IDLE);

endmodule
